pulse_scheduler: RTL

Round-robin scheduler that shares a single pulse output between four requesters. Each granted requester receives one high pulse whose width, in clock cycles, it supplies itself, followed by a fixed low guard gap. The block sits between the free-running `clock` generator and the pulse consumers, so one `signal` line is time-multiplexed with known ownership.

---
 rtl/pulse_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pulse_scheduler.sv
// pulse_scheduler
// Shares one registered pulse line between four requesters in round-robin
// order. The winner gets one high pulse whose width it supplies itself
// (0 is treated as 1), followed by GAP low guard cycles before the next
// grant can happen.
//
// Ports:
//   clock      system clock, all state changes on its rising edge
//   reset      asynchronous, active-high reset
//   req        level request, one bit per requester
//   widths     packed pulse widths, requester i uses widths[i*W +: W]
//   signal     shared pulse output (registered)
//   grant      one-hot owner of the current pulse (registered)
//   owner      binary index of the last granted requester (held)
//   done       one-cycle strobe in the cycle after the pulse falls
//   busy       high whenever the FSM is not IDLE
//   fsm_state  current FSM state, for debug and checker binding
//
// Handshake: there is no ready back to the requesters. req is a level
// that is only sampled in IDLE; a requester learns it was served by
// seeing its grant bit, and may drop req at any time after that without
// affecting the pulse in flight.
module pulse_scheduler #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int GAP = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] widths,
  output logic           signal,
  output logic [N-1:0]   grant,
  output logic [1:0]     owner,
  output logic           done,
  output logic           busy,
  output logic [1:0]     fsm_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [W-1:0] GAP_LD = W'(GAP - 1);

  logic [1:0]   ptr;
  logic [W-1:0] cnt;

  logic [1:0]   win;
  logic [1:0]   idx;
  logic         found;
  logic [N-1:0] win_onehot;
  logic [W-1:0] wsel;
  logic [W-1:0] wl;
  logic [1:0]   ptr_next;

  // Round-robin search: first set request at or after ptr, wrapping.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = 2'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  // A zero width still yields a one-cycle pulse.
  assign wsel     = widths[win*W +: W];
  assign wl       = (wsel == '0) ? W'(1) : wsel;
  assign ptr_next = 2'((int'(win) + 1) % N);

  assign busy = (fsm_state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_state <= S_IDLE;
      signal    <= 1'b0;
      grant     <= '0;
      owner     <= '0;
      done      <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (fsm_state)
        S_IDLE: begin
          if (|req) begin
            grant     <= win_onehot;
            owner     <= win;
            signal    <= 1'b1;
            cnt       <= wl - W'(1);
            ptr       <= ptr_next;
            fsm_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          // cnt was loaded with wl-1, so exiting at zero gives wl high cycles.
          if (cnt != '0) begin
            cnt <= cnt - W'(1);
          end else begin
            signal    <= 1'b0;
            grant     <= '0;
            done      <= 1'b1;
            cnt       <= GAP_LD;
            fsm_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            fsm_state <= S_IDLE;
          end else begin
            cnt <= cnt - W'(1);
          end
        end
        default: begin
          fsm_state <= S_IDLE;
          signal    <= 1'b0;
          grant     <= '0;
        end
      endcase
    end
  end

endmodule
